vga_sync_receiver: RTL and testbench
====================================

# vga_sync_receiver

Receive side of the on-chip video interface: consumes the `hsync`/`vsync`/`rgb` triple produced by the pattern generators, locks to its timing, and re-derives pixel coordinates as a registered pixel stream. It also produces a per-frame CRC-16 signature of visible pixels. It sits between any generator top and on-chip self-test/compare logic, giving benches and silicon a way to check generator output without an external monitor.

## Interface

Parameters:
- `H_DISPLAY`, 256: visible pixels per line.
- `H_BACK`, 23: clocks from first `hsync`-low cycle to pixel 0 of the line.
- `V_DISPLAY`, 240: visible lines per frame.
- `V_TOP`, 5: index of the hsync falling edge, counted after a `vsync` falling edge, that starts line 0.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `hsync` in 1: active-high horizontal sync.
- `vsync` in 1: active-high vertical sync.
- `rgb` in 3: pixel colour.
- `locked` out 1: timing lock achieved.
- `sync_err` out 1: one-cycle pulse on loss of lock.
- `pix_valid` out 1: `pix_*` carry a visible pixel.
- `pix_x` out 9: pixel column, 0..H_DISPLAY−1.
- `pix_y` out 9: pixel row, 0..V_DISPLAY−1.
- `pix_rgb` out 3: pixel colour.
- `line_len` out 10: measured clocks per line, valid while `locked`.
- `frame_lines` out 10: measured lines per frame, valid while `locked`.
- `frame_done` out 1: one-cycle pulse at each frame end while locked.
- `frame_crc` out 16: signature of the last completed frame.

## Operation

- **Input stage:**
  - `hsync`, `vsync` and `rgb` are registered once.
  - Falling edges are detected on the registered copies as prev=1, cur=0.
- **Line timing:**
  - A 10-bit clock counter restarts at each hsync fall.
  - The value at the next fall is the line period.
  - A 10-bit line counter restarts at each vsync fall and increments at each hsync fall.
  - If a vsync fall and an hsync fall occur in the same cycle, the vsync fall is processed first, so that hsync fall counts as k=1.
- **Coordinates:**
  - The line started by the k-th hsync fall after a vsync fall has index k−V_TOP.
  - Indices 0..V_DISPLAY−1 are visible.
  - Pixel x of a line is the input sample H_BACK+x clocks after the first hsync-low cycle, for x < H_DISPLAY.
- **FSM states:**
  - SEARCH:
    - Entered on reset.
    - Waits for a vsync fall, then goes to TRAIN.
  - TRAIN:
    - Latches the first line period measured.
    - Every later period in the frame must match it; any mismatch sets an internal bad flag.
    - At the next vsync fall: if the flag is clear and lines ≥ V_TOP+V_DISPLAY, latch `line_len` and `frame_lines` and go to LOCKED.
    - Otherwise clear the flag and stay in TRAIN.
  - LOCKED:
    - Emits pixels.
    - Goes to SEARCH with a `sync_err` pulse if any of these occur:
      - a line period ≠ `line_len`;
      - a vsync fall with line count ≠ `frame_lines`;
      - the line counter exceeds `frame_lines`.
- **Timeout:** in TRAIN or LOCKED, if the clock counter saturates at 1023 without an hsync fall, go to SEARCH. `sync_err` pulses only if the state was LOCKED.
- **Output gating:** `pix_valid` is asserted only in LOCKED. `pix_x`, `pix_y` and `pix_rgb` hold their last values when `pix_valid` is low.
- **CRC:**
  - CRC-16-CCITT (polynomial 0x1021), seed 0xFFFF.
  - Shifts in the 3 bits of each valid pixel, MSB first, in one clock.
  - At a LOCKED vsync fall: `frame_crc` takes the accumulator, `frame_done` pulses, and the accumulator re-seeds.
  - The accumulator re-seeds on any FSM entry to LOCKED.

## Timing

- **Reset values:** all outputs are 0, the FSM is in SEARCH, and the CRC accumulator is 0xFFFF.
  - Reset applied mid-frame takes effect next edge and discards the partial frame and lock.
- **Latency:** an `rgb` sample at input cycle t appears on `pix_rgb` at t+2, with matching `pix_x`, `pix_y` and `pix_valid`.
- `locked` rises at t+2, where t is the first `vsync`-low cycle of the qualifying vsync fall.
- `locked` falls at t+2 of the offending input cycle, in the same cycle as `sync_err`.
- `frame_done` occurs at t+2 of the vsync fall. `frame_crc` updates in the same cycle and is stable until the next `frame_done`.
- No input handshake exists: the block is always ready, one sample per clock.

## Configuration

- `VGA_RX_FRAME_CRC_EN`:
  - Defined: the CRC logic is built as described.
  - Undefined: the CRC logic is omitted and `frame_crc` is tied to 0. `frame_done`, lock and the pixel stream are unchanged.

## Test plan

- **Lock:** drive standard timing with default parameters (309 clocks/line, 262 lines/frame) -> `locked`=1 at t+2 of the second vsync fall, `line_len`=309, `frame_lines`=262.
- **Pixel alignment:** rgb=5 at pixel (0,0), rgb=3 at (255,239), others 0 -> exactly two `pix_valid` pulses with nonzero rgb, each 2 cycles after input, with correct x/y. Total valid cycles per frame = 61440.
- **Glitch:** while locked, one line of 308 clocks -> `sync_err` 1-cycle pulse, `locked`=0, relock after two further vsync falls.
- **Timeout:** while locked, hold `hsync` low for 1100 clocks -> `sync_err` pulse when the counter reaches 1023, FSM in SEARCH, no `pix_valid`.
- **CRC:** three identical frames after lock -> identical `frame_crc` each `frame_done`, matching the bench model. Change one pixel -> CRC differs. With the macro undefined -> `frame_crc`=0.
- **Reset:** assert `reset` one cycle mid-line while locked -> next cycle all outputs 0, and relock on the normal two-vsync schedule.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - sync-locked video receiver with pixel stream and frame CRC
// Optional frame signature built only when VGA_RX_FRAME_CRC_EN is defined; frame_crc reads 0 otherwise.
module vga_sync_receiver #(
    parameter int H_DISPLAY = 256,
    parameter int H_BACK    = 23,
    parameter int V_DISPLAY = 240,
    parameter int V_TOP     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic        locked,
    output logic        sync_err,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic        frame_done,
    output logic [15:0] frame_crc
);
    localparam logic [9:0] H_LO    = 10'(H_BACK);
    localparam logic [9:0] H_HI    = 10'(H_BACK + H_DISPLAY);
    localparam logic [9:0] K_LO    = 10'(V_TOP);
    localparam logic [9:0] K_HI    = 10'(V_TOP + V_DISPLAY);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;
    state_t state, state_n;

    logic       hs_r, vs_r, hs_p, vs_p;
    logic [2:0] rgb_r;
    logic [9:0] cnt, lines, train_len;
    logic       have_len, bad;

    logic       hs_fall, vs_fall, timeout, bad_now;
    logic       visible, valid_now, err, go_lock, frame_end;
    logic [9:0] cur_h, lines_inc, cur_k;

    always_ff @(posedge clk) begin
        if (reset) begin
            {hs_r, vs_r, hs_p, vs_p} <= '0;
            rgb_r <= '0;
        end else begin
            hs_p  <= hs_r;
            vs_p  <= vs_r;
            hs_r  <= hsync;
            vs_r  <= vsync;
            rgb_r <= rgb;
        end
    end

    assign hs_fall   = hs_p & ~hs_r;
    assign vs_fall   = vs_p & ~vs_r;
    assign timeout   = (cnt == CNT_MAX) & ~hs_fall;
    // cnt equals the offset from the first hsync-low sample, except on the fall cycle itself
    assign cur_h     = hs_fall ? 10'd0 : cnt;
    assign lines_inc = (lines == CNT_MAX) ? CNT_MAX : lines + 10'd1;
    assign bad_now   = bad | (hs_fall & have_len & (cnt != train_len));

    always_comb begin
        cur_k = lines;
        if (vs_fall)
            cur_k = hs_fall ? 10'd1 : 10'd0;
        else if (hs_fall)
            cur_k = lines_inc;
    end

    assign visible   = (cur_h >= H_LO) && (cur_h < H_HI) && (cur_k >= K_LO) && (cur_k < K_HI);
    assign valid_now = (state == LOCKED) && visible;
    assign locked    = (state == LOCKED);

    always_comb begin
        state_n   = state;
        err       = 1'b0;
        go_lock   = 1'b0;
        frame_end = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall)
                    state_n = TRAIN;
            end
            TRAIN: begin
                if (timeout) begin
                    state_n = SEARCH;
                end else if (vs_fall && !bad_now && (lines >= K_HI)) begin
                    state_n = LOCKED;
                    go_lock = 1'b1;
                end
            end
            LOCKED: begin
                if (timeout || (hs_fall && (cnt != line_len)) ||
                    (vs_fall && (lines != frame_lines)) || (cur_k > frame_lines)) begin
                    state_n = SEARCH;
                    err     = 1'b1;
                end else if (vs_fall) begin
                    frame_end = 1'b1;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            cnt       <= '0;
            lines     <= '0;
            train_len <= '0;
            have_len  <= 1'b0;
            bad       <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= hs_fall ? 10'd1 : ((cnt == CNT_MAX) ? CNT_MAX : cnt + 10'd1);
            if (vs_fall)
                lines <= hs_fall ? 10'd1 : 10'd0;
            else if (hs_fall)
                lines <= lines_inc;
            // each training frame re-measures its reference period from scratch
            if ((state != TRAIN) || vs_fall) begin
                have_len <= 1'b0;
                bad      <= 1'b0;
            end else if (hs_fall) begin
                if (!have_len) begin
                    train_len <= cnt;
                    have_len  <= 1'b1;
                end else if (cnt != train_len) begin
                    bad <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            sync_err    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            pix_valid  <= valid_now;
            sync_err   <= err;
            frame_done <= frame_end;
            if (valid_now) begin
                pix_x   <= 9'(cur_h - H_LO);
                pix_y   <= 9'(cur_k - K_LO);
                pix_rgb <= rgb_r;
            end
            if (go_lock) begin
                line_len    <= train_len;
                frame_lines <= lines;
            end
        end
    end

`ifdef VGA_RX_FRAME_CRC_EN
    logic [15:0] crc_acc;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [2:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 2; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_acc   <= 16'hFFFF;
            frame_crc <= 16'h0000;
        end else if (go_lock) begin
            crc_acc <= 16'hFFFF;
        end else if (frame_end) begin
            frame_crc <= crc_acc;
            crc_acc   <= valid_now ? crc_step(16'hFFFF, rgb_r) : 16'hFFFF;
        end else if (valid_now) begin
            crc_acc <= crc_step(crc_acc, rgb_r);
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed self-checking bench for vga_sync_receiver
module tb_vga_sync_receiver;
    localparam int HD = 8;
    localparam int HB = 3;
    localparam int VD = 4;
    localparam int VT = 2;
    localparam int LLEN = 16;
    localparam int NL = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [2:0]  rgb = 3'd0;
    logic        locked, sync_err, pix_valid, frame_done;
    logic [8:0]  pix_x, pix_y;
    logic [2:0]  pix_rgb;
    logic [9:0]  line_len, frame_lines;
    logic [15:0] frame_crc;

    vga_sync_receiver #(
        .H_DISPLAY(HD), .H_BACK(HB), .V_DISPLAY(VD), .V_TOP(VT)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .locked(locked), .sync_err(sync_err), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .line_len(line_len), .frame_lines(frame_lines),
        .frame_done(frame_done), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // output monitor, sampled on the falling edge
    int          vcount = 0, nz_n = 0, serr_n = 0, serr_wide = 0, fd_n = 0;
    int          serr_cyc = -1, lock_cyc = -1, fd_cyc = -1;
    logic [8:0]  nz_x[4], nz_y[4];
    logic [2:0]  nz_rgb[4];
    int          nz_cyc[4];
    logic [15:0] fd_crc[8];
    logic        serr_prev = 1'b0, lock_prev = 1'b0;

    always @(negedge clk) begin
        if (pix_valid) begin
            vcount++;
            if (pix_rgb != 3'd0) begin
                if (nz_n < 4) begin
                    nz_x[nz_n]   = pix_x;
                    nz_y[nz_n]   = pix_y;
                    nz_rgb[nz_n] = pix_rgb;
                    nz_cyc[nz_n] = cyc;
                end
                nz_n++;
            end
        end
        if (sync_err) begin
            serr_n++;
            serr_cyc = cyc;
            if (serr_prev) serr_wide++;
        end
        serr_prev = sync_err;
        if (locked && !lock_prev) lock_cyc = cyc;
        lock_prev = locked;
        if (frame_done) begin
            if (fd_n < 8) fd_crc[fd_n] = frame_crc;
            fd_cyc = cyc;
            fd_n++;
        end
    end

    int         mod_x = -1, mod_y = -1;
    logic [2:0] mod_v = 3'd0;
    int         lstart[16];
    int         t00, t73;

    function automatic logic [2:0] pat(input int x, input int y, input int mx, input int my,
                                       input logic [2:0] mv);
        if (x == mx && y == my) return mv;
        if (x == 0 && y == 0) return 3'd5;
        if (x == HD - 1 && y == VD - 1) return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic [15:0] model_crc(input int mx, input int my, input logic [2:0] mv);
        logic [15:0] c;
        logic [2:0]  v;
        logic        fb;
        c = 16'hFFFF;
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++) begin
                v = pat(x, y, mx, my, mv);
                for (int b = 2; b >= 0; b--) begin
                    fb = c[15] ^ v[b];
                    c  = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h1021;
                end
            end
        return c;
    endfunction

    // one frame: line L starts with its hsync fall; vsync falls together with line 0
    task automatic drive_frame(input int nl, input int sp_line, input int sp_len, input int rst_line);
        for (int L = 0; L < nl; L++) begin
            int len;
            int row;
            len = (L == sp_line) ? sp_len : LLEN;
            row = L + 1 - VT;
            for (int d = 0; d < len; d++) begin
                @(posedge clk);
                #1;
                reset = (L == rst_line && d == 5);
                hsync = (d >= len - 3);
                vsync = (L >= nl - 2);
                if (row >= 0 && row < VD && d >= HB && d < HB + HD)
                    rgb = pat(d - HB, row, mod_x, mod_y, mod_v);
                else
                    rgb = 3'd0;
                if (d == 0) lstart[L] = cyc;
                if (row == 0 && d == HB) t00 = cyc;
                if (row == VD - 1 && d == HB + HD - 1) t73 = cyc;
                if (L == rst_line && d == 6) begin
                    check("rst_flags_pix", {locked, sync_err, pix_valid, frame_done, pix_x, pix_y, pix_rgb}, 32'd0);
                    check("rst_measure", {line_len, frame_lines}, 32'd0);
                    check("rst_crc", frame_crc, 32'd0);
                end
            end
        end
    endtask

    initial begin
        int          v0;
        logic [15:0] crc_a, crc_b;

        repeat (3) @(posedge clk);
        #1;
        check("reset_flags_pix", {locked, sync_err, pix_valid, frame_done, pix_x, pix_y, pix_rgb}, 32'd0);
        check("reset_measure", {line_len, frame_lines}, 32'd0);
        check("reset_crc", frame_crc, 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        drive_frame(NL, -1, 0, -1);
        check("train_not_locked", locked, 32'd0);

        v0 = vcount;
        drive_frame(NL, -1, 0, -1);
        check("lock_rise_cyc", lock_cyc, lstart[0] + 2);
        check("line_len", line_len, 32'd16);
        check("frame_lines", frame_lines, 32'd9);
        check("valid_per_frame", vcount - v0, HD * VD);
        check("nonzero_pixels", nz_n, 32'd2);
        check("pix00_cyc", nz_cyc[0], t00 + 2);
        check("pix00_xyrgb", {nz_x[0], nz_y[0], nz_rgb[0]}, {9'd0, 9'd0, 3'd5});
        check("pixlast_cyc", nz_cyc[1], t73 + 2);
        check("pixlast_xyrgb", {nz_x[1], nz_y[1], nz_rgb[1]}, {9'd7, 9'd3, 3'd3});
        check("pix_hold", {pix_valid, pix_x, pix_y, pix_rgb}, {1'b0, 9'd7, 9'd3, 3'd3});

        drive_frame(NL, -1, 0, -1);
        check("frame_done_cyc", fd_cyc, lstart[0] + 2);
        drive_frame(NL, -1, 0, -1);
        mod_x = 2; mod_y = 1; mod_v = 3'd6;
        drive_frame(NL, -1, 0, -1);
        mod_x = -1; mod_y = -1; mod_v = 3'd0;

        // frame 5: line 3 is one clock short
        drive_frame(NL, 3, LLEN - 1, -1);
`ifdef VGA_RX_FRAME_CRC_EN
        crc_a = model_crc(-1, -1, 3'd0);
        crc_b = model_crc(2, 1, 3'd6);
`else
        crc_a = 16'h0000;
        crc_b = 16'h0000;
`endif
        check("frame_done_count", fd_n, 32'd4);
        check("crc_frame1", fd_crc[0], crc_a);
        check("crc_frame2", fd_crc[1], crc_a);
        check("crc_frame3", fd_crc[2], crc_a);
        check("crc_changed_pixel", fd_crc[3], crc_b);
        check("glitch_err_cyc", serr_cyc, lstart[4] + 2);
        check("glitch_err_count", serr_n, 32'd1);
        check("glitch_unlocked", locked, 32'd0);

        drive_frame(NL, -1, 0, -1);
        check("glitch_still_training", locked, 32'd0);
        drive_frame(NL, -1, 0, -1);
        check("glitch_relock_cyc", lock_cyc, lstart[0] + 2);
        check("glitch_relocked", locked, 32'd1);

        // one extra line pushes the line counter past frame_lines
        drive_frame(NL + 1, -1, 0, -1);
        check("overflow_err_cyc", serr_cyc, lstart[9] + 2);
        check("overflow_err_count", serr_n, 32'd2);

        drive_frame(NL, -1, 0, -1);
        v0 = vcount;
        drive_frame(NL, 2, 1100, -1);
        check("timeout_lock_cyc", lock_cyc, lstart[0] + 2);
        check("timeout_err_cyc", serr_cyc, lstart[2] + 1025);
        check("timeout_err_count", serr_n, 32'd3);
        check("timeout_valid_count", vcount - v0, 2 * HD);
        check("timeout_unlocked", locked, 32'd0);
        check("err_pulse_width", serr_wide, 32'd0);

        drive_frame(NL, -1, 0, -1);
        drive_frame(NL, -1, 0, 3);
        check("pre_reset_lock_cyc", lock_cyc, lstart[0] + 2);
        check("after_reset_unlocked", locked, 32'd0);
        drive_frame(NL, -1, 0, -1);
        drive_frame(NL, -1, 0, -1);
        check("reset_relock_cyc", lock_cyc, lstart[0] + 2);
        check("reset_relock_measure", {line_len, frame_lines}, {10'd16, 10'd9});
        check("reset_no_err", serr_n, 32'd3);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
